vram_arbiter: RTL

Shares the single external 16-bit asynchronous VRAM port between the display fetch engine (read-only, deadline-critical) and the MPU path coming from the SPI memory bridge (read/write, byte-enabled). It sits inside Core, between those two requesters and the active-high vram_* control bus that the top level inverts onto the pins. It sequences each access over a fixed number of cycles, inserts bus turnaround after writes, and guarantees the MPU bounded latency.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_request_latch.sv | 76 +++++++
 rtl/vram_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM port arbiter.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 18;
  localparam int unsigned VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_e;

  // Requester ids recorded with each granted access
  localparam logic DISP = 1'b0;
  localparam logic MPU  = 1'b1;

endpackage

// File: rtl/vram_request_latch.sv
// Holds the fields of the granted request for the duration of its VRAM access.
module vram_request_latch
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant,
  input  logic              grant_owner,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              mpu_wr,
  input  logic [1:0]        mpu_be,
  input  logic [ADDR_W-1:0] mpu_addr,
  input  logic [DATA_W-1:0] mpu_wdata,
  output logic              owner,
  output logic              wr,
  output logic [1:0]        be,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Capture the winner's fields on grant; display is always a full-word read
  always_comb begin
    owner_d = owner_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (grant) begin
      if (grant_owner == MPU) begin
        owner_d = MPU;
        wr_d    = mpu_wr;
        be_d    = mpu_be;
        addr_d  = mpu_addr;
        wdata_d = mpu_wdata;
      end else begin
        owner_d = DISP;
        wr_d    = 1'b0;
        be_d    = 2'b11;
        addr_d  = disp_addr;
      end
    end
  end

  // Latch registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= DISP;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign owner = owner_q;
  assign wr    = wr_q;
  assign be    = be_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Shares the VRAM port between display fetch and MPU with bounded MPU latency.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MPU_MAX_WAIT  = 4,
  parameter int unsigned ADDR_W        = VRAM_ADDR_W,
  parameter int unsigned DATA_W        = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              mpu_req,
  input  logic              mpu_wr,
  input  logic [1:0]        mpu_be,
  input  logic [ADDR_W-1:0] mpu_addr,
  input  logic [DATA_W-1:0] mpu_wdata,
  output logic              mpu_ack,
  output logic              mpu_rvalid,
  output logic [DATA_W-1:0] mpu_rdata,
  output logic              vram_en,
  output logic              vram_rd,
  output logic              vram_wr,
  output logic [1:0]        vram_be,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data_out,
  input  logic [DATA_W-1:0] vram_data_in
);

  localparam int unsigned        CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned        WAIT_W   = $clog2(MPU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MPU_MAX_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              vram_en_q, vram_en_d;
  logic              vram_rd_q, vram_rd_d;
  logic              vram_wr_q, vram_wr_d;
  logic [1:0]        vram_be_q, vram_be_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic              mpu_rvalid_q, mpu_rvalid_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic [DATA_W-1:0] mpu_rdata_q, mpu_rdata_d;

  logic              last_cyc, mpu_win, disp_win, win_wr, can_grant, defer, grant;
  logic              nxt_wr;
  logic [1:0]        nxt_be;
  logic              lat_owner, lat_wr;
  logic [1:0]        lat_be;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // Priority and grant window; a read following a write waits one turnaround cycle
  always_comb begin
    last_cyc  = (state_q == ACCESS) && (cnt_q == LAST_CNT);
    mpu_win   = mpu_req && (!disp_req || (wait_q == WAIT_MAX));
    disp_win  = disp_req && !mpu_win;
    win_wr    = mpu_win && mpu_wr;
    can_grant = (state_q == IDLE) || (state_q == TURN) || last_cyc;
    defer     = last_cyc && lat_wr && (disp_win || mpu_win) && !win_wr;
    grant     = can_grant && (disp_win || mpu_win) && !defer;
  end

  assign disp_ack = grant && disp_win && !reset;
  assign mpu_ack  = grant && mpu_win && !reset;

  // Next state, starvation counter, bus controls and read-data capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    disp_rvalid_d = 1'b0;
    mpu_rvalid_d  = 1'b0;
    disp_rdata_d  = disp_rdata_q;
    mpu_rdata_d   = mpu_rdata_q;

    case (state_q)
      IDLE:   if (grant) state_d = ACCESS;
      ACCESS: begin
        if (!last_cyc)  cnt_d = cnt_q + CNT_W'(1);
        else if (grant) state_d = ACCESS;
        else if (defer) state_d = TURN;
        else            state_d = IDLE;
      end
      TURN:   state_d = grant ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
    if (grant) cnt_d = '0;

    if (!mpu_req || (grant && mpu_win))
      wait_d = '0;
    else if (grant && disp_win && (wait_q != WAIT_MAX))
      wait_d = wait_q + WAIT_W'(1);

    if (last_cyc && !lat_wr) begin
      if (lat_owner == MPU) begin
        mpu_rvalid_d = 1'b1;
        mpu_rdata_d  = vram_data_in;
      end else begin
        disp_rvalid_d = 1'b1;
        disp_rdata_d  = vram_data_in;
      end
    end

    nxt_wr    = grant ? win_wr : lat_wr;
    nxt_be    = grant ? (mpu_win ? mpu_be : 2'b11) : lat_be;
    vram_en_d = (state_d == ACCESS);
    vram_rd_d = vram_en_d && !nxt_wr;
    vram_wr_d = vram_en_d && nxt_wr;
    vram_be_d = vram_en_d ? nxt_be : 2'b00;
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wait_q        <= '0;
      vram_en_q     <= 1'b0;
      vram_rd_q     <= 1'b0;
      vram_wr_q     <= 1'b0;
      vram_be_q     <= 2'b00;
      disp_rvalid_q <= 1'b0;
      mpu_rvalid_q  <= 1'b0;
      disp_rdata_q  <= '0;
      mpu_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      vram_en_q     <= vram_en_d;
      vram_rd_q     <= vram_rd_d;
      vram_wr_q     <= vram_wr_d;
      vram_be_q     <= vram_be_d;
      disp_rvalid_q <= disp_rvalid_d;
      mpu_rvalid_q  <= mpu_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      mpu_rdata_q   <= mpu_rdata_d;
    end
  end

  vram_request_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_latch (
    .clk         (clk),
    .reset       (reset),
    .grant       (grant),
    .grant_owner (mpu_win),
    .disp_addr   (disp_addr),
    .mpu_wr      (mpu_wr),
    .mpu_be      (mpu_be),
    .mpu_addr    (mpu_addr),
    .mpu_wdata   (mpu_wdata),
    .owner       (lat_owner),
    .wr          (lat_wr),
    .be          (lat_be),
    .addr        (lat_addr),
    .wdata       (lat_wdata)
  );

  assign vram_en       = vram_en_q;
  assign vram_rd       = vram_rd_q;
  assign vram_wr       = vram_wr_q;
  assign vram_be       = vram_be_q;
  assign vram_addr     = lat_addr;
  assign vram_data_out = lat_wdata;
  assign disp_rvalid   = disp_rvalid_q;
  assign disp_rdata    = disp_rdata_q;
  assign mpu_rvalid    = mpu_rvalid_q;
  assign mpu_rdata     = mpu_rdata_q;

endmodule
